vid_timing_gen: RTL and testbench

VID_TIMING_GEN -- requirements
Module: vid_timing_gen

---
 rtl/vid_timing_gen.sv | 160 ++++++++++++++++
 tb/tb_vid_timing_gen.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/vid_timing_gen.sv
// Composite video timing generator: line/frame counters, line-type FSM,
// pixel addressing (x/y/vid_time/sof) and a 2-clk aligned composite DAC level.
module vid_timing_gen #(
  parameter int LINE_CLKS   = 1016,
  parameter int HSYNC_CLKS  = 75,
  parameter int ACT_START   = 170,
  parameter int PIX_DIV     = 3,
  parameter int ACT_PIX     = 226,
  parameter int FRAME_LINES = 262,
  parameter int VSYNC_LINES = 3,
  parameter int ACT_LINE0   = 16,
  parameter int ACT_LINES   = 244
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vid,
  output logic       vid_time,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic       sof,
  output logic [1:0] comp
);

  localparam logic [1:0] ST_VSYNC  = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_BLANK  = 2'd2;

  localparam logic [9:0] LINE_LAST  = 10'(LINE_CLKS - 1);
  localparam logic [9:0] HSYNC_END  = 10'(HSYNC_CLKS);
  localparam logic [9:0] BROAD_END  = 10'(LINE_CLKS - HSYNC_CLKS);
  localparam logic [9:0] ACT_H0     = 10'(ACT_START);
  localparam logic [9:0] ACT_H1     = 10'(ACT_START + ACT_PIX * PIX_DIV);
  localparam logic [8:0] FRAME_LAST = 9'(FRAME_LINES - 1);
  localparam logic [8:0] VS_END     = 9'(VSYNC_LINES);
  localparam logic [8:0] ACT_Y0     = 9'(ACT_LINE0);
  localparam logic [8:0] ACT_Y1     = 9'(ACT_LINE0 + ACT_LINES);
  localparam logic [3:0] PHASE_LAST = 4'(PIX_DIV - 1);
  localparam logic [8:0] X_LAST     = 9'(ACT_PIX - 1);

  logic [9:0] hcnt_r;
  logic [8:0] lcnt_r;
  logic [1:0] state_r;
  logic [3:0] phase_r;
  logic [8:0] x_r;
  logic [7:0] y_r;
  logic       vid_time_r;
  logic       sof_r;
  logic       sync_d1_r, sync_d2_r;
  logic       act_d1_r, act_d2_r;
  logic [1:0] comp_r;

  logic       hcnt_wrap_s;
  logic [8:0] lcnt_next_s;
  logic       sync_s;
  logic       act_s;
  logic [7:0] y_s;
  logic       phase_wrap_s;
  logic [1:0] comp_s;

  function automatic logic [1:0] line_state(input logic [8:0] l);
    if (l < VS_END) begin
      line_state = ST_VSYNC;
    end else if ((l >= ACT_Y0) && (l < ACT_Y1)) begin
      line_state = ST_ACTIVE;
    end else begin
      line_state = ST_BLANK;
    end
  endfunction

  // Counter wrap, raw sync/active window and line-relative row
  always_comb begin
    hcnt_wrap_s  = (hcnt_r == LINE_LAST);
    lcnt_next_s  = (lcnt_r == FRAME_LAST) ? 9'd0 : (lcnt_r + 9'd1);
    phase_wrap_s = (phase_r == PHASE_LAST);
    act_s        = (state_r == ST_ACTIVE) && (hcnt_r >= ACT_H0) && (hcnt_r < ACT_H1);
    case (state_r)
      ST_VSYNC:  sync_s = (hcnt_r < BROAD_END);
      ST_ACTIVE: sync_s = (hcnt_r < HSYNC_END);
      ST_BLANK:  sync_s = (hcnt_r < HSYNC_END);
      default:   sync_s = 1'b1;
    endcase
    if (state_r == ST_ACTIVE) begin
      y_s = 8'(lcnt_r - ACT_Y0);
    end else begin
      y_s = 8'd0;
    end
  end

  // Sync takes priority; white only inside the delayed active window
  always_comb begin
    if (sync_d2_r) begin
      comp_s = 2'b00;
    end else if (act_d2_r && vid) begin
      comp_s = 2'b10;
    end else begin
      comp_s = 2'b01;
    end
  end

  // Horizontal/line counters; line type is re-evaluated only when lcnt advances
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt_r  <= 10'd0;
      lcnt_r  <= 9'd0;
      state_r <= ST_VSYNC;
    end else if (hcnt_wrap_s) begin
      hcnt_r  <= 10'd0;
      lcnt_r  <= lcnt_next_s;
      state_r <= line_state(lcnt_next_s);
    end else begin
      hcnt_r  <= hcnt_r + 10'd1;
    end
  end

  // Registered pixel address outputs; vid_time_r doubles as "window already open"
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vid_time_r <= 1'b0;
      x_r        <= 9'd0;
      y_r        <= 8'd0;
      sof_r      <= 1'b0;
      phase_r    <= 4'd0;
    end else begin
      vid_time_r <= act_s;
      y_r        <= y_s;
      sof_r      <= act_s && !vid_time_r && (y_s == 8'd0);
      if (act_s && vid_time_r) begin
        phase_r <= phase_wrap_s ? 4'd0 : (phase_r + 4'd1);
        x_r     <= (phase_wrap_s && (x_r != X_LAST)) ? (x_r + 9'd1) : x_r;
      end else begin
        phase_r <= 4'd0;
        x_r     <= 9'd0;
      end
    end
  end

  // Two-stage delay of sync/window so the DAC level lines up with vid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_d1_r <= 1'b0;
      sync_d2_r <= 1'b0;
      act_d1_r  <= 1'b0;
      act_d2_r  <= 1'b0;
      comp_r    <= 2'b01;
    end else begin
      sync_d1_r <= sync_s;
      sync_d2_r <= sync_d1_r;
      act_d1_r  <= act_s;
      act_d2_r  <= act_d1_r;
      comp_r    <= comp_s;
    end
  end

  assign vid_time = vid_time_r;
  assign x        = x_r;
  assign y        = y_r;
  assign sof      = sof_r;
  assign comp     = comp_r;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Randomized bench for vid_timing_gen against an arithmetic timing model,
// using a scaled-down geometry so several frames fit in a short run.
module tb_vid_timing_gen;

  localparam int LC  = 40;
  localparam int HS  = 4;
  localparam int AS  = 8;
  localparam int PD  = 3;
  localparam int AP  = 8;
  localparam int FL  = 20;
  localparam int VS  = 3;
  localparam int AL0 = 4;
  localparam int AL  = 12;
  localparam int FRAME_CLKS = LC * FL;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vid = 1'b0;
  logic       vid_time;
  logic [8:0] x;
  logic [7:0] y;
  logic       sof;
  logic [1:0] comp;

  int checks = 0;
  int failures = 0;
  int k = 0;
  int last_sof = -1;
  int comp_white = 0;

  vid_timing_gen #(
    .LINE_CLKS(LC), .HSYNC_CLKS(HS), .ACT_START(AS), .PIX_DIV(PD), .ACT_PIX(AP),
    .FRAME_LINES(FL), .VSYNC_LINES(VS), .ACT_LINE0(AL0), .ACT_LINES(AL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vid(vid), .vid_time(vid_time),
    .x(x), .y(y), .sof(sof), .comp(comp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (k=%0d)", tag, obs, exp, k);
    end
  endtask

  // Position p counts clocks since timing restart; everything follows from it
  function automatic int pline(input int p);
    return (p / LC) % FL;
  endfunction

  function automatic int phpos(input int p);
    return p % LC;
  endfunction

  function automatic bit pact(input int p);
    int l, h;
    l = pline(p);
    h = phpos(p);
    return (l >= AL0) && (l < AL0 + AL) && (h >= AS) && (h < AS + AP * PD);
  endfunction

  function automatic bit psync(input int p);
    if (pline(p) < VS) return phpos(p) < LC - HS;
    return phpos(p) < HS;
  endfunction

  // Outputs after each edge: address from position k-1, DAC from k-3 plus current vid
  always @(posedge clk) begin
    logic r, v;
    int p, p3, l, ex, ey, ecomp;
    bit evt, esof;
    r = rst_n;
    v = vid;
    #1;
    if (!r) begin
      k = 0;
      last_sof = -1;
      check("rst_vid_time", vid_time, 0);
      check("rst_x", x, 0);
      check("rst_y", y, 0);
      check("rst_sof", sof, 0);
      check("rst_comp", comp, 1);
    end else begin
      k++;
      p = k - 1;
      l = pline(p);
      evt = pact(p);
      ex = evt ? (phpos(p) - AS) / PD : 0;
      ey = (l >= AL0 && l < AL0 + AL) ? l - AL0 : 0;
      esof = evt && (phpos(p) == AS) && (l == AL0);
      p3 = k - 3;
      if (p3 < 0) ecomp = 1;
      else if (psync(p3)) ecomp = 0;
      else if (pact(p3) && v) ecomp = 2;
      else ecomp = 1;
      check("vid_time", vid_time, evt);
      check("x", x, ex);
      check("y", y, ey);
      check("sof", sof, esof);
      check("comp", comp, ecomp);
      if (comp == 2'b10) comp_white++;
      if (sof === 1'b1) begin
        if (last_sof < 0) check("sof_latency", k, AL0 * LC + AS + 1);
        else check("sof_gap", k - last_sof, FRAME_CLKS);
        last_sof = k;
      end
    end
  end

  initial begin
    int n;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * FRAME_CLKS + 10) begin
      vid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    n = 0;
    while ((k % FRAME_CLKS) != (10 * LC + 20) && n < 2 * FRAME_CLKS) begin
      vid = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    check("seek_mid_frame", k % FRAME_CLKS, 10 * LC + 20);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME_CLKS + 50) begin
      vid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    vid = 1'b1;
    comp_white = 0;
    repeat (FRAME_CLKS) @(negedge clk);
    check("white_count", comp_white, AL * AP * PD);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
